// File: rtl/receiver_pkg.sv
// Shared types and default sizing for the serial receiver front end.
package receiver_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is a parameter
// so idle-high lines do not produce a spurious edge when reset is released.
module sync2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            o_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// LSB-first 8N1 deserialiser feeding controlunit; holds each word until loaddata
// and reports framing errors and overruns.
module serial_receiver
    import receiver_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_in,
    input  logic                  loaddata,
    output logic [DATA_WIDTH-1:0] inputdata,
    output logic                  inputdata_ready,
    output logic                  frame_error,
    output logic                  overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIDX_LAST = BW'(DATA_WIDTH - 1);

    rx_state_t             r_state;
    rx_state_t             w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_bidx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  w_rx_s;
    logic                  w_bit_end;
    logic                  w_data_smp;
    logic                  w_stop_smp;
    logic                  w_consume;

    sync2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (rx_in),
        .o_q     (w_rx_s)
    );

    assign w_bit_end  = (r_cnt == CNT_LAST);
    assign w_data_smp = (r_state == DATA) && w_bit_end;
    assign w_stop_smp = (r_state == STOP) && w_bit_end;
    assign w_consume  = inputdata_ready && loaddata;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (!w_rx_s) w_state_nxt = START;
            // A start bit that is high again at its midpoint was only a glitch
            START: if (r_cnt == CNT_MID) w_state_nxt = w_rx_s ? IDLE : DATA;
            DATA:  if (w_bit_end && (r_bidx == BIDX_LAST)) w_state_nxt = STOP;
            STOP:  if (w_bit_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bidx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt  <= '0;
                r_bidx <= '0;
            end else begin
                r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
                if (w_data_smp) r_bidx <= r_bidx + 1'b1;
            end
        end
    end

    // Consume is applied first so a stop sample in the same cycle can reload the word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift         <= '0;
            inputdata       <= '0;
            inputdata_ready <= 1'b0;
            frame_error     <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (w_data_smp) r_shift <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
            if (w_consume) begin
                inputdata_ready <= 1'b0;
                overrun         <= 1'b0;
            end
            if (w_stop_smp) begin
                if (!w_rx_s) begin
                    frame_error <= 1'b1;
                end else if (!inputdata_ready || loaddata) begin
                    inputdata       <= r_shift;
                    inputdata_ready <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver with default sizing (8 data bits, 16 clocks per bit).
module tb_serial_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       loaddata;
    logic [7:0] inputdata;
    logic       inputdata_ready;
    logic       frame_error;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    int rdy_edge;
    int fe_cnt;
    int fe_edge;
    int rdy_low;

    serial_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_in           (rx_in),
        .loaddata        (loaddata),
        .inputdata       (inputdata),
        .inputdata_ready (inputdata_ready),
        .frame_error     (frame_error),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edge e counts from the first edge on which the line is captured low.
    task automatic drive_frame(input logic [7:0] data, input logic stop_bit,
                               input int ld_edge, input int abort_edge);
        int   idx;
        logic prev;
        rdy_edge = -1;
        fe_cnt   = 0;
        fe_edge  = -1;
        rdy_low  = 0;
        @(posedge clk);
        #1;
        rx_in    = 1'b0;
        loaddata = 1'b0;
        prev     = inputdata_ready;
        for (int e = 0; e < 160; e++) begin
            @(posedge clk);
            #1;
            if (inputdata_ready && !prev && rdy_edge < 0) rdy_edge = e;
            if (!inputdata_ready) rdy_low++;
            if (frame_error) begin
                fe_cnt++;
                fe_edge = e;
            end
            prev = inputdata_ready;
            if (e == abort_edge) begin
                loaddata = 1'b0;
                reset    = 1'b0;
                return;
            end
            idx = (e + 1) / 16;
            if (idx == 0)      rx_in = 1'b0;
            else if (idx <= 8) rx_in = data[idx-1];
            else if (idx == 9) rx_in = stop_bit;
            else               rx_in = 1'b1;
            loaddata = (e + 1 == ld_edge);
        end
        loaddata = 1'b0;
    endtask

    task automatic consume();
        loaddata = 1'b1;
        @(posedge clk);
        #1;
        loaddata = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        rx_in    = 1'b1;
        loaddata = 1'b0;
        idle(3);
        checks++; if (inputdata !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", inputdata); end
        checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", inputdata_ready); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_fe got %b exp 0", frame_error); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun); end
        reset = 1'b1;
        idle(5);
    endtask

    task automatic test_single();
        drive_frame(8'hA5, 1'b1, -1, -1);
        checks++; if (rdy_edge != 154) begin errors++; $display("FAIL single_latency got %0d exp 154", rdy_edge); end
        checks++; if (inputdata !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", inputdata); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL single_ovr got %b exp 0", overrun); end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL single_fe got %0d exp 0", fe_cnt); end
        idle(10);
        consume();
        checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL single_consume got %b exp 0", inputdata_ready); end
        checks++; if (inputdata !== 8'hA5) begin errors++; $display("FAIL single_hold got %h exp a5", inputdata); end
        idle(5);
        consume();
        checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL stray_load got %b exp 0", inputdata_ready); end
        idle(20);
    endtask

    task automatic test_frame_error();
        drive_frame(8'h3C, 1'b0, -1, -1);
        idle(30);
        checks++; if (fe_cnt != 1) begin errors++; $display("FAIL fe_count got %0d exp 1", fe_cnt); end
        checks++; if (fe_edge != 154) begin errors++; $display("FAIL fe_edge got %0d exp 154", fe_edge); end
        checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL fe_ready got %b exp 0", inputdata_ready); end
        checks++; if (inputdata !== 8'hA5) begin errors++; $display("FAIL fe_data got %h exp a5", inputdata); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL fe_after got %b exp 0", frame_error); end
    endtask

    task automatic test_overrun();
        drive_frame(8'h11, 1'b1, -1, -1);
        idle(20);
        checks++; if (inputdata !== 8'h11) begin errors++; $display("FAIL ovr_first got %h exp 11", inputdata); end
        drive_frame(8'h22, 1'b1, -1, -1);
        idle(20);
        checks++; if (inputdata !== 8'h11) begin errors++; $display("FAIL ovr_keep got %h exp 11", inputdata); end
        checks++; if (inputdata_ready !== 1'b1) begin errors++; $display("FAIL ovr_ready got %b exp 1", inputdata_ready); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
        consume();
        checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL ovr_clr_ready got %b exp 0", inputdata_ready); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr_flag got %b exp 0", overrun); end
        idle(10);
    endtask

    task automatic test_simultaneous();
        drive_frame(8'h33, 1'b1, -1, -1);
        idle(20);
        checks++; if (inputdata !== 8'h33) begin errors++; $display("FAIL sim_first got %h exp 33", inputdata); end
        drive_frame(8'h7E, 1'b1, 154, -1);
        idle(10);
        checks++; if (inputdata !== 8'h7E) begin errors++; $display("FAIL sim_data got %h exp 7e", inputdata); end
        checks++; if (inputdata_ready !== 1'b1) begin errors++; $display("FAIL sim_ready got %b exp 1", inputdata_ready); end
        checks++; if (rdy_low != 0) begin errors++; $display("FAIL sim_ready_gap got %0d exp 0", rdy_low); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL sim_ovr got %b exp 0", overrun); end
        consume();
        idle(10);
    endtask

    task automatic test_glitch();
        int toggles;
        toggles = 0;
        rx_in = 1'b0;
        idle(3);
        rx_in = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (inputdata_ready || frame_error || overrun) toggles++;
        end
        checks++; if (toggles != 0) begin errors++; $display("FAIL glitch_outputs got %0d exp 0", toggles); end
        checks++; if (inputdata !== 8'h7E) begin errors++; $display("FAIL glitch_data got %h exp 7e", inputdata); end
        drive_frame(8'hFF, 1'b1, -1, -1);
        checks++; if (rdy_edge != 154) begin errors++; $display("FAIL glitch_next_latency got %0d exp 154", rdy_edge); end
        checks++; if (inputdata !== 8'hFF) begin errors++; $display("FAIL glitch_next_data got %h exp ff", inputdata); end
        idle(10);
    endtask

    task automatic test_reset_mid();
        checks++; if (inputdata_ready !== 1'b1) begin errors++; $display("FAIL rmid_pre_ready got %b exp 1", inputdata_ready); end
        drive_frame(8'hC3, 1'b1, -1, 85);
        #1;
        checks++; if (inputdata !== 8'h00) begin errors++; $display("FAIL rmid_data got %h exp 00", inputdata); end
        checks++; if (inputdata_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b exp 0", inputdata_ready); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_ovr got %b exp 0", overrun); end
        checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL rmid_fe got %b exp 0", frame_error); end
        rx_in = 1'b1;
        idle(3);
        reset = 1'b1;
        idle(5);
        drive_frame(8'h5A, 1'b1, -1, -1);
        checks++; if (rdy_edge != 154) begin errors++; $display("FAIL rmid_next_latency got %0d exp 154", rdy_edge); end
        checks++; if (inputdata !== 8'h5A) begin errors++; $display("FAIL rmid_next_data got %h exp 5a", inputdata); end
        checks++; if (fe_cnt != 0) begin errors++; $display("FAIL rmid_next_fe got %0d exp 0", fe_cnt); end
        idle(10);
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame_error();
        test_overrun();
        test_simultaneous();
        test_glitch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
# serial_receiver

Input stage directly upstream of `controlunit`: deserialises an asynchronous, LSB-first, 8N1-style serial line into a parallel word and presents it with `inputdata_ready`. Holds the word until the control unit acknowledges with `loaddata`. Flags framing errors and overruns so that the datapath only ever loads valid, unconsumed words.

## Interface
- `DATA_WIDTH`, 8: bits per frame.
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit. Must be even and at least 4.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx_in` in 1: serial line, asynchronous to `clk`, idles high.
- `loaddata` in 1: acknowledge from `controlunit`; consumes the held word.
- `inputdata` out `DATA_WIDTH`: received word, stable while `inputdata_ready`=1.
- `inputdata_ready` out 1: level; a word is held and unconsumed.
- `frame_error` out 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` out 1: sticky; a frame completed while the previous word was still unconsumed.

## Operation
- **Synchroniser:** `rx_in` passes through 2 flops reset to 1; the FSM sees only the synchronised `rx_s`.
- **Bit counter:** `cnt`, width $clog2(CLKS_PER_BIT). **Bit index:** `bidx`, width $clog2(DATA_WIDTH)+1. Both are cleared on every state entry.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** `rx_s`=0 moves to START.
- **START:** at `cnt`=CLKS_PER_BIT/2−1 (mid start bit):
  - `rx_s`=0 moves to DATA.
  - `rx_s`=1 is a glitch; return to IDLE with no outputs.
- **DATA:** at `cnt`=CLKS_PER_BIT−1, shift `rx_s` into the MSB of the shift register (right shift, so LSB is received first) and increment `bidx`. After the DATA_WIDTH-th sample, move to STOP.
- **STOP:** at `cnt`=CLKS_PER_BIT−1, sample `rx_s` and return to IDLE.
  - `rx_s`=1 and (`inputdata_ready`=0 or `loaddata`=1): load `inputdata` from the shift register and set `inputdata_ready`.
  - `rx_s`=1, `inputdata_ready`=1 and `loaddata`=0: discard the new word, keep the old one, set `overrun`.
  - `rx_s`=0: pulse `frame_error`; no load, and `inputdata_ready` is unchanged.
- **Handshake:**
  - `inputdata_ready` clears on the edge after `loaddata`=1 is seen while it is 1.
  - `loaddata` while `inputdata_ready`=0 is ignored.
  - `overrun` clears on the same consuming `loaddata`.
- **Simultaneous events:** `loaddata` in the same cycle as a valid stop sample: the new word is loaded, `inputdata_ready` stays 1, and no overrun is raised.
- **Reset:** reset mid-frame aborts immediately.
  - All outputs and registers return to reset values: FSM=IDLE, `inputdata`=0, `inputdata_ready`=0, `frame_error`=0, `overrun`=0, sync flops=1.
  - After release, a line held low is treated as a new start bit.

## Timing
- **Latency:** edge 0 is the first edge at which the first sync flop captures the start bit low. `inputdata_ready` is 1 after edge L = 2 + CLKS_PER_BIT/2 + (DATA_WIDTH+1)·CLKS_PER_BIT. With defaults, L=154.
- **Sample points:** data bit k is sampled at edge 2 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- **Error pulse:** `frame_error` is high for exactly the one cycle following the stop-sample edge.
- **Back-to-back frames:** after a stop sample the FSM is in IDLE, so a start bit immediately following the stop bit is accepted.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Package `receiver_pkg`:** `typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t`, plus default constants for DATA_WIDTH and CLKS_PER_BIT.
- **Sub-module `sync2ff`:** generic 2-flop synchroniser with a reset value parameter, reused for other asynchronous inputs.
- **Top module:** FSM, counters, shift register and output registers stay in `serial_receiver`. Structure is one sequential state process, one combinational next-state process and one output/datapath sequential process.

## Test plan
- **Single frame:** reset, then frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1) with `loaddata`=0. Expect `inputdata`=0xA5 and `inputdata_ready`=1 after edge 154. Pulse `loaddata`; `inputdata_ready`=0 on the next edge.
- **Framing error:** frame 0x3C with stop bit 0. Expect `frame_error` high for 1 cycle, `inputdata_ready` remains 0 and `inputdata` unchanged.
- **Overrun:** frames 0x11 then 0x22 without `loaddata`. Expect `inputdata`=0x11 and `overrun`=1. A later `loaddata` clears both `inputdata_ready` and `overrun`.
- **Simultaneous load:** assert `loaddata` exactly on the stop-sample cycle of a second frame 0x7E. Expect `inputdata`=0x7E, `inputdata_ready` stays 1, `overrun`=0.
- **Glitch rejection:** hold `rx_in` low for 3 cycles, then high. Expect the FSM to return to IDLE with no outputs toggled. A following frame 0xFF is received correctly.
- **Reset mid-frame:** assert `reset`=0 during data bit 4. Expect all outputs 0 immediately. After release, frame 0x5A is received correctly.
